// File: rtl/data_ram_resp_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface data_ram_resp_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_we, mem_re,
    input  mem_rdata, mem_ready, mem_busy, mem_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_we, mem_re,
    output mem_rdata, mem_ready, mem_busy, mem_err
  );
endinterface

// File: rtl/data_ram_resp.sv
// Data-memory responder: byte-lane RAM with programmable wait states and a ready pulse.
// Optional macro RAM_MISALIGN_TRAP_EN: misaligned accesses are dropped and flagged with mem_err.
module data_ram_lane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wbyte,
  output logic [7:0]       rbyte
);
  logic [7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wbyte;
  end

  assign rbyte = mem[idx];
endmodule

module data_ram_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  data_ram_resp_if.slave  bus
);
  localparam int          NUM_LANES = 4;
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAST      = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
  } req_t;

  logic [1:0]  state;
  logic [3:0]  cnt;
  req_t        req, live, cur;
  logic [31:0] rdata;
  logic        err;
  logic        accept, go_resp;
  logic [31:0] off;
  logic        in_range, misalign, acc_ok;
  logic [IDX_W-1:0] idx;

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] wbytes, rbytes;

  assign live.addr = bus.mem_addr;
  assign live.data = bus.mem_wdata;
  assign live.be   = bus.mem_be;
  assign live.we   = bus.mem_we;

  assign accept = (state == S_IDLE) && (bus.mem_we || bus.mem_re);

  // With zero wait states the commit edge is the accept edge, so decode the live request.
  assign cur = (state == S_IDLE) ? live : req;

  assign go_resp = ((state == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && (cnt == LAST));

  // Below-base addresses wrap to huge offsets, so one compare covers both ends.
  assign off      = cur.addr - ADDR_BASE;
  assign in_range = (off < SPAN);
  assign idx      = off[IDX_W+1:2];

`ifdef RAM_MISALIGN_TRAP_EN
  assign misalign = |cur.addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign acc_ok = in_range && !misalign;
  assign wbytes = cur.data;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign lane_we[k] = rst && go_resp && cur.we && cur.be[k] && acc_ok;
      data_ram_lane #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_lane (
        .clk   (clk),
        .we    (lane_we[k]),
        .idx   (idx),
        .wbyte (wbytes[k]),
        .rbyte (rbytes[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      req   <= '0;
      rdata <= 32'd0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          req   <= live;
          cnt   <= 4'd0;
          state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: if (cnt == LAST) state <= S_RESP;
                else             cnt   <= cnt + 4'd1;
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        err <= !acc_ok;
        // A combined we&re is a write; load data is left untouched.
        if (!cur.we) rdata <= acc_ok ? rbytes : 32'd0;
      end
    end
  end

  assign bus.mem_rdata = rdata;
  assign bus.mem_ready = (state == S_RESP);
  assign bus.mem_busy  = (state != S_IDLE);
  assign bus.mem_err   = err;
endmodule
